fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_pkg.sv | 33 +++
 rtl/fifo_wr_arbiter_if.sv | 27 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 30 +++
 rtl/fifo_wr_arbiter.sv | 120 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared types and the round-robin search used by the FIFO write-port arbiter.
package fifo_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

   localparam int RR_MAX_REQ = 64;

   // First set bit of req searching upward from last+1, wrapping modulo num_req; -1 if none.
   function automatic int rr_search(input logic [RR_MAX_REQ-1:0] req,
                                    input int                    num_req,
                                    input int                    last);
      int pick;
      int idx;
      pick = -1;
      for (int k = 1; k <= RR_MAX_REQ; k++) begin
         if (k <= num_req) begin
            idx = (last + k) % num_req;
            if ((pick < 0) && req[idx[5:0]]) begin
               pick = idx;
            end else begin
               pick = pick;
            end
         end else begin
            pick = pick;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side handshake plus FIFO write-side signals of the write-port arbiter.
interface fifo_wr_arbiter_if #(
   parameter int WIDTH   = 16,
   parameter int NUM_REQ = 4
);
   localparam int IDX_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ*WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]       req_last;
   logic [NUM_REQ-1:0]       req_ready;
   logic                     fifo_full;
   logic                     fifo_wr_en;
   logic [WIDTH-1:0]         fifo_data_in;
   logic [IDX_W-1:0]         grant_id;
   logic                     busy;

   modport master (
      output req_valid, req_data, req_last, fifo_full,
      input  req_ready, fifo_wr_en, fifo_data_in, grant_id, busy
   );

   modport slave (
      input  req_valid, req_data, req_last, fifo_full,
      output req_ready, fifo_wr_en, fifo_data_in, grant_id, busy
   );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after i_last, wrapping modulo NUM_REQ.
module rr_pick
   import fifo_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_last,
   output logic [IDX_W-1:0]   o_grant,
   output logic               o_any_valid
);

   logic [RR_MAX_REQ-1:0] w_req_ext;
   int                    w_pick;

   // Widen the request vector and run the shared search.
   always_comb begin
      w_req_ext                = '0;
      w_req_ext[NUM_REQ-1:0]   = i_req;
      w_pick                   = rr_search(w_req_ext, NUM_REQ, int'(i_last));
      o_any_valid              = (w_pick >= 0);
      if (o_any_valid) begin
         o_grant = IDX_W'(w_pick);
      end else begin
         o_grant = '0;
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port between NUM_REQ producers,
// one burst per grant, ending on last or after MAX_BURST beats.
module fifo_wr_arbiter
   import fifo_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int NUM_REQ   = 4,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              rst,
   fifo_wr_arbiter_if.slave  io_bus
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   arb_state_t         r_state;
   logic [IDX_W-1:0]   r_grant_id;
   logic [IDX_W-1:0]   r_last_grant;
   logic [CNT_W-1:0]   r_beat_cnt;
   logic               r_busy;

   arb_state_t         w_next_state;
   logic [IDX_W-1:0]   w_next_grant;
   logic [IDX_W-1:0]   w_next_last;
   logic [CNT_W-1:0]   w_next_cnt;
   logic [NUM_REQ-1:0] w_req_ready;
   logic               w_wr_en;
   logic [WIDTH-1:0]   w_data;
   logic [IDX_W-1:0]   w_pick;
   logic               w_any_valid;
   logic [WIDTH-1:0]   w_lane [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign w_lane[gi] = io_bus.req_data[gi*WIDTH +: WIDTH];
   end

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .i_req       (io_bus.req_valid),
      .i_last      (r_last_grant),
      .o_grant     (w_pick),
      .o_any_valid (w_any_valid)
   );

   // Next-state, burst accounting and write-port datapath.
   always_comb begin
      w_next_state = r_state;
      w_next_grant = r_grant_id;
      w_next_last  = r_last_grant;
      w_next_cnt   = r_beat_cnt;
      w_req_ready  = '0;
      w_wr_en      = 1'b0;
      w_data       = '0;
      case (r_state)
         IDLE: begin
            if (w_any_valid) begin
               w_next_state = BURST;
               w_next_grant = w_pick;
               w_next_cnt   = '0;
            end else begin
               w_next_state = IDLE;
            end
         end
         BURST: begin
            w_data                  = w_lane[r_grant_id];
            w_req_ready[r_grant_id] = ~io_bus.fifo_full;
            w_wr_en                 = io_bus.req_valid[r_grant_id] & ~io_bus.fifo_full;
            if (w_wr_en) begin
               w_next_cnt = r_beat_cnt + CNT_W'(1);
               if (io_bus.req_last[r_grant_id] || (r_beat_cnt == CNT_W'(MAX_BURST - 1))) begin
                  w_next_state = IDLE;
                  w_next_last  = r_grant_id;
               end else begin
                  w_next_state = BURST;
               end
            end else begin
               w_next_cnt = r_beat_cnt;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
      // Handshake strobes are forced quiet while reset is held, even mid-burst.
      if (rst) begin
         w_req_ready = '0;
         w_wr_en     = 1'b0;
      end else begin
         w_req_ready = w_req_ready;
      end
   end

   // State, grant and beat counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_grant_id   <= '0;
         r_last_grant <= IDX_W'(NUM_REQ - 1);
         r_beat_cnt   <= '0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_grant_id   <= w_next_grant;
         r_last_grant <= w_next_last;
         r_beat_cnt   <= w_next_cnt;
         r_busy       <= (w_next_state == BURST);
      end
   end

   assign io_bus.req_ready    = w_req_ready;
   assign io_bus.fifo_wr_en   = w_wr_en;
   assign io_bus.fifo_data_in = w_data;
   assign io_bus.grant_id     = r_grant_id;
   assign io_bus.busy         = r_busy;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, WIDTH=16, MAX_BURST=4).
module tb_fifo_wr_arbiter;

   localparam int WIDTH     = 16;
   localparam int NUM_REQ   = 4;
   localparam int MAX_BURST = 4;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_err    = 0;

   fifo_wr_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus ();

   fifo_wr_arbiter #(
      .WIDTH     (WIDTH),
      .NUM_REQ   (NUM_REQ),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_lane(input int i, input logic [15:0] d);
      bus.req_data[i*WIDTH +: WIDTH] = d;
   endtask

   // Ends the current cycle: guard against writing into a full FIFO, then step past the edge.
   task automatic cyc();
      #1;
      n_checks++;
      assert (!(bus.fifo_wr_en === 1'b1 && bus.fifo_full === 1'b1)) else begin
         n_err++;
         $error("FAIL wr_en_while_full: observed wr_en=%b full=%b expected no write", bus.fifo_wr_en, bus.fifo_full);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      bus.req_valid = '0;
      bus.req_last  = '0;
      bus.req_data  = '0;
      bus.fifo_full = 1'b0;
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      int writes;
      int r;
      logic exp_idle;

      // 1: reset with all requesters valid
      rst           = 1'b1;
      bus.req_valid = 4'hF;
      bus.req_last  = 4'h0;
      bus.fifo_full = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) set_lane(i, 16'h1000 + 16'(i));
      cyc();
      cyc();
      #1;
      chk("t1 rst ready", 32'(bus.req_ready), 32'h0);
      chk("t1 rst wr_en", 32'(bus.fifo_wr_en), 32'h0);
      chk("t1 rst busy", 32'(bus.busy), 32'h0);
      chk("t1 rst grant", 32'(bus.grant_id), 32'h0);
      rst = 1'b0;
      #1;
      chk("t1 idle busy", 32'(bus.busy), 32'h0);
      chk("t1 idle wr_en", 32'(bus.fifo_wr_en), 32'h0);
      cyc();
      #1;
      chk("t1 grant", 32'(bus.grant_id), 32'h0);
      chk("t1 busy", 32'(bus.busy), 32'h1);
      chk("t1 wr_en", 32'(bus.fifo_wr_en), 32'h1);
      chk("t1 data", 32'(bus.fifo_data_in), 32'h1000);

      // 2: single requester 2, three-beat packet
      do_reset();
      bus.req_valid = 4'b0100;
      set_lane(2, 16'h00A1);
      #1;
      chk("t2 idle wr_en", 32'(bus.fifo_wr_en), 32'h0);
      cyc();
      #1;
      chk("t2 grant", 32'(bus.grant_id), 32'h2);
      chk("t2 ready", 32'(bus.req_ready), 32'h4);
      chk("t2 wr1", 32'(bus.fifo_wr_en), 32'h1);
      chk("t2 data1", 32'(bus.fifo_data_in), 32'h00A1);
      cyc();
      set_lane(2, 16'h00A2);
      #1;
      chk("t2 wr2", 32'(bus.fifo_wr_en), 32'h1);
      chk("t2 data2", 32'(bus.fifo_data_in), 32'h00A2);
      cyc();
      set_lane(2, 16'h00A3);
      bus.req_last = 4'b0100;
      #1;
      chk("t2 wr3", 32'(bus.fifo_wr_en), 32'h1);
      chk("t2 data3", 32'(bus.fifo_data_in), 32'h00A3);
      cyc();
      bus.req_valid = 4'b0000;
      bus.req_last  = 4'b0000;
      #1;
      chk("t2 end busy", 32'(bus.busy), 32'h0);
      chk("t2 end wr_en", 32'(bus.fifo_wr_en), 32'h0);

      // 3: all four requesters contend continuously
      do_reset();
      bus.req_valid = 4'hF;
      for (int i = 0; i < NUM_REQ; i++) set_lane(i, 16'h3000 + 16'(i));
      writes = 0;
      for (int c = 0; c < 25; c++) begin
         #1;
         exp_idle = ((c % 5) == 0);
         r        = (c / 5) % NUM_REQ;
         chk($sformatf("t3 wr_en c%0d", c), 32'(bus.fifo_wr_en), exp_idle ? 32'h0 : 32'h1);
         chk($sformatf("t3 data c%0d", c), 32'(bus.fifo_data_in), exp_idle ? 32'h0 : 32'h3000 + 32'(r));
         if (!exp_idle) chk($sformatf("t3 grant c%0d", c), 32'(bus.grant_id), 32'(r));
         if (bus.fifo_wr_en === 1'b1) writes++;
         cyc();
      end
      chk("t3 total writes", 32'(writes), 32'd20);

      // 4: requester 1 stalled by fifo_full after beat 2
      do_reset();
      bus.req_valid = 4'b0010;
      set_lane(1, 16'h00B1);
      #1;
      chk("t4 idle busy", 32'(bus.busy), 32'h0);
      cyc();
      #1;
      chk("t4 grant", 32'(bus.grant_id), 32'h1);
      chk("t4 data1", 32'(bus.fifo_data_in), 32'h00B1);
      cyc();
      set_lane(1, 16'h00B2);
      #1;
      chk("t4 wr2", 32'(bus.fifo_wr_en), 32'h1);
      chk("t4 data2", 32'(bus.fifo_data_in), 32'h00B2);
      cyc();
      bus.fifo_full = 1'b1;
      set_lane(1, 16'h00B3);
      #1;
      chk("t4 full1 ready", 32'(bus.req_ready), 32'h0);
      chk("t4 full1 wr_en", 32'(bus.fifo_wr_en), 32'h0);
      chk("t4 full1 busy", 32'(bus.busy), 32'h1);
      cyc();
      #1;
      chk("t4 full2 ready", 32'(bus.req_ready), 32'h0);
      chk("t4 full2 wr_en", 32'(bus.fifo_wr_en), 32'h0);
      chk("t4 full2 grant", 32'(bus.grant_id), 32'h1);
      cyc();
      bus.fifo_full = 1'b0;
      #1;
      chk("t4 ready3", 32'(bus.req_ready), 32'h2);
      chk("t4 wr3", 32'(bus.fifo_wr_en), 32'h1);
      chk("t4 data3", 32'(bus.fifo_data_in), 32'h00B3);
      cyc();
      set_lane(1, 16'h00B4);
      #1;
      chk("t4 wr4", 32'(bus.fifo_wr_en), 32'h1);
      chk("t4 data4", 32'(bus.fifo_data_in), 32'h00B4);
      cyc();
      #1;
      chk("t4 bubble busy", 32'(bus.busy), 32'h0);
      chk("t4 bubble wr_en", 32'(bus.fifo_wr_en), 32'h0);
      cyc();
      #1;
      chk("t4 regrant busy", 32'(bus.busy), 32'h1);
      chk("t4 regrant id", 32'(bus.grant_id), 32'h1);

      // 5: reset pulsed mid-burst of requester 3
      do_reset();
      bus.req_valid = 4'b1000;
      set_lane(3, 16'h00C1);
      set_lane(0, 16'h00D0);
      cyc();
      #1;
      chk("t5 grant3", 32'(bus.grant_id), 32'h3);
      chk("t5 data1", 32'(bus.fifo_data_in), 32'h00C1);
      bus.req_valid = 4'b1001;
      cyc();
      set_lane(3, 16'h00C2);
      #1;
      chk("t5 wr2", 32'(bus.fifo_wr_en), 32'h1);
      chk("t5 data2", 32'(bus.fifo_data_in), 32'h00C2);
      cyc();
      rst = 1'b1;
      #1;
      chk("t5 rst wr_en", 32'(bus.fifo_wr_en), 32'h0);
      chk("t5 rst ready", 32'(bus.req_ready), 32'h0);
      cyc();
      rst = 1'b0;
      #1;
      chk("t5 idle busy", 32'(bus.busy), 32'h0);
      chk("t5 idle wr_en", 32'(bus.fifo_wr_en), 32'h0);
      cyc();
      #1;
      chk("t5 grant0", 32'(bus.grant_id), 32'h0);
      chk("t5 busy", 32'(bus.busy), 32'h1);
      chk("t5 data0", 32'(bus.fifo_data_in), 32'h00D0);

      // 6: granted requester 0 pauses mid-packet while requester 1 waits
      do_reset();
      bus.req_valid = 4'b0011;
      set_lane(0, 16'h00E1);
      set_lane(1, 16'h00F1);
      cyc();
      #1;
      chk("t6 grant", 32'(bus.grant_id), 32'h0);
      chk("t6 data1", 32'(bus.fifo_data_in), 32'h00E1);
      cyc();
      set_lane(0, 16'h00E2);
      #1;
      chk("t6 wr2", 32'(bus.fifo_wr_en), 32'h1);
      cyc();
      bus.req_valid = 4'b0010;
      bus.req_last  = 4'b0001;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("t6 hold grant %0d", k), 32'(bus.grant_id), 32'h0);
         chk($sformatf("t6 hold wr_en %0d", k), 32'(bus.fifo_wr_en), 32'h0);
         chk($sformatf("t6 hold busy %0d", k), 32'(bus.busy), 32'h1);
         chk($sformatf("t6 hold ready %0d", k), 32'(bus.req_ready), 32'h1);
         cyc();
      end
      bus.req_valid = 4'b0011;
      set_lane(0, 16'h00E3);
      #1;
      chk("t6 wr3", 32'(bus.fifo_wr_en), 32'h1);
      chk("t6 data3", 32'(bus.fifo_data_in), 32'h00E3);
      chk("t6 grant3", 32'(bus.grant_id), 32'h0);
      cyc();
      bus.req_last = 4'b0000;
      #1;
      chk("t6 bubble busy", 32'(bus.busy), 32'h0);
      chk("t6 bubble wr_en", 32'(bus.fifo_wr_en), 32'h0);
      cyc();
      #1;
      chk("t6 grant1", 32'(bus.grant_id), 32'h1);
      chk("t6 data f1", 32'(bus.fifo_data_in), 32'h00F1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
